icache_line_fill: RTL and testbench

Memory-side refill engine for the instruction cache. It accepts one line-fill request at a time from the icache miss path and issues a single burst read to the memory interface. It assembles four 32-bit response beats into a 128-bit line and returns the line to the icache as a one-cycle fill response. A kill from the fetch pipeline cancels the outstanding fill: the engine still drains the burst, but no response is delivered.

---
 rtl/drac_icache_pkg.sv | 19 +
 rtl/icache_line_fill.sv | 138 +++++++++++++
 tb/tb_icache_line_fill.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/drac_icache_pkg.sv
// Shared icache refill definitions: line/beat/address geometry and the
// fill engine state encoding.
package drac_icache_pkg;

  localparam int unsigned ICACHE_PADDR_WIDTH = 32;
  localparam int unsigned ICACHE_LINE_WIDTH  = 128;
  localparam int unsigned ICACHE_BEAT_WIDTH  = 32;
  localparam int unsigned ICACHE_FILL_BEATS  = ICACHE_LINE_WIDTH / ICACHE_BEAT_WIDTH;
  localparam int unsigned ICACHE_BEAT_CNT_W  = 2;
  localparam int unsigned ICACHE_LINE_OFFSET = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } fill_state_t;

endpackage

// File: rtl/icache_line_fill.sv
// icache_line_fill: memory-side refill engine for the instruction cache.
// Takes one line-fill request at a time, issues a single burst read, gathers
// four response beats into a line and returns it as a one-cycle fill pulse.
// A kill from the fetch pipeline lets the burst drain but drops the response.
//
// Ports:
//   clk_i, rstn_i          clock, async active-low reset
//   ireq_*                 fill request from the icache miss path (+ kill)
//   ifill_*                fill response to the icache (valid is a pulse)
//   mem_req_*              burst read request to memory
//   mem_rsp_*              response beats from memory (no backpressure)
//   busy_o                 engine is not idle
module icache_line_fill
  import drac_icache_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH = ICACHE_PADDR_WIDTH,
  parameter int unsigned LINE_WIDTH  = ICACHE_LINE_WIDTH,
  parameter int unsigned BEAT_WIDTH  = ICACHE_BEAT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   ireq_valid_i,
  input  logic [PADDR_WIDTH-1:0] ireq_paddr_i,
  output logic                   ireq_ready_o,
  input  logic                   ireq_kill_i,
  output logic                   ifill_valid_o,
  output logic [LINE_WIDTH-1:0]  ifill_data_o,
  output logic [PADDR_WIDTH-1:0] ifill_paddr_o,
  output logic                   ifill_error_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [PADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [BEAT_WIDTH-1:0]  mem_rsp_data_i,
  input  logic                   mem_rsp_error_i,
  output logic                   busy_o
);

  localparam int unsigned FILL_BEATS  = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W       = ICACHE_BEAT_CNT_W;
  localparam int unsigned OFFSET_BITS = ICACHE_LINE_OFFSET;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FILL_BEATS - 1);

  fill_state_t             state_q, state_d;
  logic [PADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    killed_q, killed_d;
  logic [BEAT_WIDTH-1:0]   beat_q [FILL_BEATS];
  logic [BEAT_WIDTH-1:0]   beat_d [FILL_BEATS];

  // Offset bits of the request address never reach the memory side.
  logic unused_paddr_lsbs;
  assign unused_paddr_lsbs = ^ireq_paddr_i[OFFSET_BITS-1:0];

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    killed_d = killed_q;
    beat_d   = beat_q;

    unique case (state_q)
      IDLE: begin
        // A request racing a kill is refused; the icache re-issues it.
        if (ireq_valid_i && !ireq_kill_i) begin
          addr_d   = {ireq_paddr_i[PADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          cnt_d    = '0;
          err_d    = 1'b0;
          killed_d = 1'b0;
          state_d  = REQ;
        end
      end
      REQ: begin
        // Request stays up even when killed; the burst must be drained.
        killed_d = killed_q | ireq_kill_i;
        if (mem_req_ready_i) begin
          state_d = FILL;
        end
      end
      FILL: begin
        killed_d = killed_q | ireq_kill_i;
        if (mem_rsp_valid_i) begin
          beat_d[cnt_q] = mem_rsp_data_i;
          err_d         = err_q | mem_rsp_error_i;
          cnt_d         = CNT_W'(cnt_q + CNT_W'(1));
          if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        killed_d = killed_q | ireq_kill_i;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      killed_q <= 1'b0;
      beat_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      killed_q <= killed_d;
      beat_q   <= beat_d;
    end
  end

  // Line assembly: beat 0 lands in the least significant slot.
  always_comb begin
    ifill_data_o = '0;
    for (int unsigned i = 0; i < FILL_BEATS; i++) begin
      ifill_data_o[i*BEAT_WIDTH +: BEAT_WIDTH] = beat_q[i];
    end
  end

  // Kill in the response cycle itself must still squash the pulse.
  assign ifill_valid_o   = (state_q == RESP) & ~killed_q & ~ireq_kill_i;
  assign ireq_ready_o    = (state_q == IDLE) & ~ireq_kill_i;
  assign mem_req_valid_o = (state_q == REQ);
  assign mem_req_addr_o  = addr_q;
  assign ifill_paddr_o   = addr_q;
  assign ifill_error_o   = err_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill with a fill-response scoreboard.
module tb_icache_line_fill;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         ireq_valid_i;
  logic [31:0]  ireq_paddr_i;
  logic         ireq_ready_o;
  logic         ireq_kill_i;
  logic         ifill_valid_o;
  logic [127:0] ifill_data_o;
  logic [31:0]  ifill_paddr_o;
  logic         ifill_error_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_rsp_valid_i;
  logic [31:0]  mem_rsp_data_i;
  logic         mem_rsp_error_i;
  logic         busy_o;

  icache_line_fill dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .ireq_valid_i    (ireq_valid_i),
    .ireq_paddr_i    (ireq_paddr_i),
    .ireq_ready_o    (ireq_ready_o),
    .ireq_kill_i     (ireq_kill_i),
    .ifill_valid_o   (ifill_valid_o),
    .ifill_data_o    (ifill_data_o),
    .ifill_paddr_o   (ifill_paddr_o),
    .ifill_error_o   (ifill_error_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .mem_rsp_error_i (mem_rsp_error_i),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    logic [31:0]  paddr;
    logic         err;
    int           at_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   t_acc;

  localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_B = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] LINE_C = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Fill responses are sampled mid-low-phase, after all negedge stimulus.
  exp_t e;
  always @(negedge clk_i) begin
    #1;
    if (rstn_i === 1'b1 && ifill_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_fill_pulse", 128'(1'b1), 128'(1'b0));
      end else begin
        e = sb_q.pop_front();
        check("fill_data",  ifill_data_o, e.data);
        check("fill_paddr", 128'(ifill_paddr_o), 128'(e.paddr));
        check("fill_error", 128'(ifill_error_o), 128'(e.err));
        check("fill_cycle", 128'(cyc), 128'(e.at_cyc));
      end
    end
  end

  task automatic issue(input logic [31:0] paddr, output int t);
    ireq_valid_i = 1'b1;
    ireq_paddr_i = paddr;
    #1 check("ireq_ready_idle", 128'(ireq_ready_o), 128'(1'b1));
    t = cyc;
    tick();
    ireq_valid_i = 1'b0;
    check("mem_req_valid_rise", 128'(mem_req_valid_o), 128'(1'b1));
    check("mem_req_addr", 128'(mem_req_addr_o), 128'({paddr[31:4], 4'h0}));
    check("ireq_ready_req", 128'(ireq_ready_o), 128'(1'b0));
  endtask

  // Holds mem_req_ready_i low for 'stall' cycles; optionally injects a stray beat.
  task automatic handshake(input int stall, input bit stray);
    logic [31:0] a;
    a = mem_req_addr_o;
    for (int s = 0; s < stall; s++) begin
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = stray && (s == 0);
      mem_rsp_data_i  = 32'hDEADBEEF;
      mem_rsp_error_i = stray && (s == 0);
      tick();
      mem_rsp_valid_i = 1'b0;
      mem_rsp_error_i = 1'b0;
      check("stall_valid_held", 128'(mem_req_valid_o), 128'(1'b1));
      check("stall_addr_stable", 128'(mem_req_addr_o), 128'(a));
      check("stall_ready_low", 128'(ireq_ready_o), 128'(1'b0));
    end
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    check("mem_req_valid_drop", 128'(mem_req_valid_o), 128'(1'b0));
    check("busy_fill", 128'(busy_o), 128'(1'b1));
  endtask

  task automatic send_line(input logic [31:0] paddr, input logic [127:0] line,
                           input logic [3:0] err_mask, input int gap,
                           input int kill_beat, input bit expect_pulse);
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = line[i*32 +: 32];
      mem_rsp_error_i = err_mask[i];
      ireq_kill_i     = (i == kill_beat);
      if (i == 3 && expect_pulse) begin
        sb_q.push_back('{line, {paddr[31:4], 4'h0}, |err_mask, cyc + 1});
      end
      tick();
      mem_rsp_valid_i = 1'b0;
      mem_rsp_error_i = 1'b0;
      ireq_kill_i     = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          check("gap_ready_low", 128'(ireq_ready_o), 128'(1'b0));
          tick();
        end
      end
    end
  endtask

  // Called on the response cycle; checks the pulse and the return to idle.
  task automatic finish_fill(input bit expect_valid);
    #1;
    check("resp_valid", 128'(ifill_valid_o), 128'(expect_valid));
    check("resp_ready_low", 128'(ireq_ready_o), 128'(1'b0));
    tick();
    check("post_ready_high", 128'(ireq_ready_o), 128'(1'b1));
    check("post_busy_low", 128'(busy_o), 128'(1'b0));
    check("post_valid_low", 128'(ifill_valid_o), 128'(1'b0));
  endtask

  initial begin
    rstn_i          = 1'b0;
    ireq_valid_i    = 1'b0;
    ireq_paddr_i    = '0;
    ireq_kill_i     = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    mem_rsp_error_i = 1'b0;
    repeat (2) tick();

    // Reset state.
    check("rst_ready", 128'(ireq_ready_o), 128'(1'b1));
    check("rst_busy", 128'(busy_o), 128'(1'b0));
    check("rst_fill_valid", 128'(ifill_valid_o), 128'(1'b0));
    check("rst_fill_error", 128'(ifill_error_o), 128'(1'b0));
    check("rst_mem_valid", 128'(mem_req_valid_o), 128'(1'b0));
    check("rst_fill_data", ifill_data_o, 128'h0);
    check("rst_fill_paddr", 128'(ifill_paddr_o), 128'h0);
    check("rst_mem_addr", 128'(mem_req_addr_o), 128'h0);
    rstn_i = 1'b1;
    tick();

    // Basic fill: minimum latency, pulse at accept + 6.
    issue(32'h8000_1234, t_acc);
    handshake(0, 1'b0);
    send_line(32'h8000_1234, LINE_A, 4'b0000, 0, -1, 1'b1);
    check("basic_latency_t6", 128'(cyc - t_acc), 128'(6));
    finish_fill(1'b1);

    // Stalled memory with a stray beat in REQ, gaps of 2 between beats.
    issue(32'h0001_00FC, t_acc);
    handshake(5, 1'b1);
    send_line(32'h0001_00FC, LINE_B, 4'b0000, 2, -1, 1'b1);
    finish_fill(1'b1);

    // Error on the second beat, then a clean fill clears it.
    issue(32'h1234_5670, t_acc);
    handshake(1, 1'b0);
    send_line(32'h1234_5670, LINE_C, 4'b0010, 1, -1, 1'b1);
    check("err_flag_set", 128'(ifill_error_o), 128'(1'b1));
    finish_fill(1'b1);
    issue(32'h8000_1234, t_acc);
    handshake(0, 1'b0);
    send_line(32'h8000_1234, LINE_A, 4'b0000, 0, -1, 1'b1);
    check("err_flag_clean", 128'(ifill_error_o), 128'(1'b0));
    finish_fill(1'b1);

    // Kill during FILL: burst drains, no pulse, ready two cycles after beat 4.
    issue(32'hCAFE_0010, t_acc);
    handshake(0, 1'b0);
    send_line(32'hCAFE_0010, LINE_B, 4'b0000, 0, 1, 1'b0);
    finish_fill(1'b0);

    // Kill coinciding with the response cycle.
    issue(32'hCAFE_0020, t_acc);
    handshake(2, 1'b0);
    send_line(32'hCAFE_0020, LINE_C, 4'b0000, 0, -1, 1'b0);
    ireq_kill_i = 1'b1;
    #1;
    check("resp_kill_valid", 128'(ifill_valid_o), 128'(1'b0));
    check("resp_kill_busy", 128'(busy_o), 128'(1'b1));
    tick();
    ireq_kill_i = 1'b0;
    #1;
    check("resp_kill_ready", 128'(ireq_ready_o), 128'(1'b1));
    check("resp_kill_idle", 128'(busy_o), 128'(1'b0));

    // Kill together with a request in IDLE: refused.
    tick();
    ireq_valid_i = 1'b1;
    ireq_paddr_i = 32'h7777_7770;
    ireq_kill_i  = 1'b1;
    #1 check("idle_kill_ready", 128'(ireq_ready_o), 128'(1'b0));
    tick();
    ireq_valid_i = 1'b0;
    ireq_kill_i  = 1'b0;
    check("idle_kill_no_req", 128'(mem_req_valid_o), 128'(1'b0));
    check("idle_kill_busy", 128'(busy_o), 128'(1'b0));
    tick();
    check("idle_kill_still_idle", 128'(busy_o), 128'(1'b0));

    // Async reset in the middle of FILL.
    issue(32'h5555_5678, t_acc);
    handshake(0, 1'b0);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h9999_0000;
    tick();
    mem_rsp_data_i  = 32'h9999_0001;
    tick();
    mem_rsp_valid_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1;
    check("arst_busy", 128'(busy_o), 128'(1'b0));
    check("arst_ready", 128'(ireq_ready_o), 128'(1'b1));
    check("arst_mem_valid", 128'(mem_req_valid_o), 128'(1'b0));
    check("arst_mem_addr", 128'(mem_req_addr_o), 128'h0);
    check("arst_fill_data", ifill_data_o, 128'h0);
    check("arst_fill_paddr", 128'(ifill_paddr_o), 128'h0);
    check("arst_fill_error", 128'(ifill_error_o), 128'(1'b0));
    check("arst_fill_valid", 128'(ifill_valid_o), 128'(1'b0));
    tick();
    rstn_i = 1'b1;
    tick();
    issue(32'h8000_1234, t_acc);
    handshake(0, 1'b0);
    send_line(32'h8000_1234, LINE_A, 4'b0000, 0, -1, 1'b1);
    check("post_rst_latency_t6", 128'(cyc - t_acc), 128'(6));
    finish_fill(1'b1);

    repeat (3) tick();
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
